// File: rtl/lzc_pkg.sv
// Shared types and helpers for the leading-bit count / normalise pipeline.
package lzc_pkg;

  typedef enum logic [1:0] {
    CLZ = 2'b00,
    CLO = 2'b01,
    CLS = 2'b10
  } lzc_mode_e;

  localparam int LZC_MAX_W     = 64;
  localparam int LZC_MAX_TAG_W = 16;

  // One extra bit so that a count equal to the full width fits.
  function automatic int lzc_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int LZC_MAX_CNT_W = lzc_cnt_w(LZC_MAX_W);

  typedef struct packed {
    logic [LZC_MAX_CNT_W-1:0] count;
    logic [LZC_MAX_W-1:0]     norm;
    logic                     all;
    logic [LZC_MAX_TAG_W-1:0] tag;
  } lzc_res_t;

  // The reserved encoding 2'b11 behaves as CLZ.
  function automatic lzc_mode_e lzc_decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   return CLO;
      2'b10:   return CLS;
      default: return CLZ;
    endcase
  endfunction

endpackage

// File: rtl/lzc_core.sv
// Combinational leading-zero counter built by recursive halving of the operand.
module lzc_core
  import lzc_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = lzc_cnt_w(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  localparam int LVLS = $clog2(WIDTH);

  logic [WIDTH-1:0] win [LVLS+1];
  logic [LVLS-1:0]  sel;

  assign win[0] = data;

  // Each level tests the upper half of the remaining window; a zero half sets
  // that count bit and slides the lower half up for the next level.
  for (genvar l = 0; l < LVLS; l++) begin : g_lvl
    localparam int H = WIDTH >> (l + 1);
    assign sel[LVLS-1-l] = ~|win[l][WIDTH-1 -: H];
    assign win[l+1]      = sel[LVLS-1-l] ? (win[l] << H) : win[l];
  end

  // A zero MSB after every level can only come from an all-zero operand.
  assign count = win[LVLS][WIDTH-1] ? {1'b0, sel} : CNT_W'(WIDTH);

endmodule

// File: rtl/lzc_norm_pipe.sv
// Two-stage CLZ/CLO/CLS counter with left-normalisation and ready/valid flow control.
module lzc_norm_pipe
  import lzc_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 4,
  localparam int CNT_W = lzc_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic [WIDTH-1:0] out_norm,
  output logic             out_all,
  output logic [TAG_W-1:0] out_tag
);

  function automatic logic [CNT_W-1:0] final_count(input logic [CNT_W-1:0] raw,
                                                   input lzc_mode_e       m);
    // The sign bit itself is not redundant, and raw is always >= 1 for CLS.
    return (m == CLS) ? raw - CNT_W'(1) : raw;
  endfunction

  function automatic logic [WIDTH-1:0] norm_shift(input logic [WIDTH-1:0] d,
                                                  input logic [CNT_W-1:0] sh);
    return (sh >= CNT_W'(WIDTH)) ? '0 : (d << sh);
  endfunction

  lzc_mode_e        mode_n;
  logic             inv;
  logic [WIDTH-1:0] core_in;
  logic [CNT_W-1:0] core_cnt;

  // CLO and CLS reduce to CLZ on a conditionally inverted operand.
  always_comb begin
    mode_n = lzc_decode_mode(in_mode);
    inv    = 1'b0;
    case (mode_n)
      CLO:     inv = 1'b1;
      CLS:     inv = in_data[WIDTH-1];
      default: inv = 1'b0;
    endcase
    core_in = inv ? ~in_data : in_data;
  end

  lzc_core #(.WIDTH(WIDTH)) u_core (
    .data  (core_in),
    .count (core_cnt)
  );

  logic             vld_p1_q, vld_p1_d;
  logic [CNT_W-1:0] cnt_p1_q, cnt_p1_d;
  logic [WIDTH-1:0] data_p1_q, data_p1_d;
  lzc_mode_e        mode_p1_q, mode_p1_d;
  logic [TAG_W-1:0] tag_p1_q, tag_p1_d;

  logic             vld_p2_q, vld_p2_d;
  logic [CNT_W-1:0] count_p2_q, count_p2_d;
  logic [WIDTH-1:0] norm_p2_q, norm_p2_d;
  logic             all_p2_q, all_p2_d;
  logic [TAG_W-1:0] tag_p2_q, tag_p2_d;

  logic             rdy_p1, rdy_p2, load_p1, load_p2;
  logic [CNT_W-1:0] fin_cnt;

  always_comb begin
    rdy_p2  = !vld_p2_q || out_ready;
    rdy_p1  = !vld_p1_q || rdy_p2;
    load_p1 = rdy_p1 && in_valid;
    load_p2 = rdy_p2 && vld_p1_q;

    // Stage 1: raw count of the (possibly inverted) operand.
    vld_p1_d  = rdy_p1 ? in_valid : vld_p1_q;
    cnt_p1_d  = load_p1 ? core_cnt : cnt_p1_q;
    data_p1_d = load_p1 ? in_data  : data_p1_q;
    mode_p1_d = load_p1 ? mode_n   : mode_p1_q;
    tag_p1_d  = load_p1 ? in_tag   : tag_p1_q;

    // Stage 2: mode-adjusted count, normalised operand and all-bits flag.
    fin_cnt    = final_count(cnt_p1_q, mode_p1_q);
    vld_p2_d   = rdy_p2 ? vld_p1_q : vld_p2_q;
    count_p2_d = load_p2 ? fin_cnt : count_p2_q;
    norm_p2_d  = load_p2 ? norm_shift(data_p1_q, fin_cnt) : norm_p2_q;
    all_p2_d   = load_p2 ? (cnt_p1_q == CNT_W'(WIDTH)) : all_p2_q;
    tag_p2_d   = load_p2 ? tag_p1_q : tag_p2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q   <= 1'b0;
      cnt_p1_q   <= '0;
      data_p1_q  <= '0;
      mode_p1_q  <= CLZ;
      tag_p1_q   <= '0;
      vld_p2_q   <= 1'b0;
      count_p2_q <= '0;
      norm_p2_q  <= '0;
      all_p2_q   <= 1'b0;
      tag_p2_q   <= '0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      cnt_p1_q   <= cnt_p1_d;
      data_p1_q  <= data_p1_d;
      mode_p1_q  <= mode_p1_d;
      tag_p1_q   <= tag_p1_d;
      vld_p2_q   <= vld_p2_d;
      count_p2_q <= count_p2_d;
      norm_p2_q  <= norm_p2_d;
      all_p2_q   <= all_p2_d;
      tag_p2_q   <= tag_p2_d;
    end
  end

  assign in_ready  = rdy_p1;
  assign out_valid = vld_p2_q;
  assign out_count = count_p2_q;
  assign out_norm  = norm_p2_q;
  assign out_all   = all_p2_q;
  assign out_tag   = tag_p2_q;

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Bench for lzc_norm_pipe: directed cases at WIDTH 32 plus a random scoreboard run at WIDTH 8/32/64.
module tb_lzc_norm_pipe;
  import lzc_pkg::*;

  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, out_ready;
  logic [1:0]    mode;
  logic [TW-1:0] tag;
  logic [7:0]    din8;
  logic [31:0]   din32;
  logic [63:0]   din64;

  logic irdy8, irdy32, irdy64, ovld8, ovld32, ovld64, all8, all32, all64;
  logic [3:0]    cnt8;
  logic [5:0]    cnt32;
  logic [6:0]    cnt64;
  logic [7:0]    nrm8;
  logic [31:0]   nrm32;
  logic [63:0]   nrm64;
  logic [TW-1:0] otag8, otag32, otag64;

  int total = 0;
  int bad   = 0;
  lzc_res_t exp_q [3][$];

  always #5 clk = ~clk;

  lzc_norm_pipe #(.WIDTH(8), .TAG_W(TW)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy8), .in_data(din8),
    .in_mode(mode), .in_tag(tag), .out_valid(ovld8), .out_ready(out_ready),
    .out_count(cnt8), .out_norm(nrm8), .out_all(all8), .out_tag(otag8));

  lzc_norm_pipe #(.WIDTH(32), .TAG_W(TW)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy32), .in_data(din32),
    .in_mode(mode), .in_tag(tag), .out_valid(ovld32), .out_ready(out_ready),
    .out_count(cnt32), .out_norm(nrm32), .out_all(all32), .out_tag(otag32));

  lzc_norm_pipe #(.WIDTH(64), .TAG_W(TW)) u_w64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy64), .in_data(din64),
    .in_mode(mode), .in_tag(tag), .out_valid(ovld64), .out_ready(out_ready),
    .out_count(cnt64), .out_norm(nrm64), .out_all(all64), .out_tag(otag64));

  task automatic chk_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: walk from the MSB counting bits equal to the leading bit of interest.
  function automatic lzc_res_t ref_model(input logic [63:0] d, input logic [1:0] m,
                                         input int w, input logic [TW-1:0] t);
    lzc_res_t    r;
    logic [63:0] mask;
    logic        lead;
    int          n;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    d    = d & mask;
    lead = (m == 2'b01) ? 1'b1 : (m == 2'b10) ? d[w-1] : 1'b0;
    n    = 0;
    for (int i = w - 1; i >= 0; i--) begin
      if (d[i] != lead) break;
      n++;
    end
    r     = '0;
    r.all = (n == w);
    if (m == 2'b10) n--;
    r.count = LZC_MAX_CNT_W'(n);
    r.norm  = (n >= w) ? 64'd0 : ((d << n) & mask);
    r.tag   = LZC_MAX_TAG_W'(t);
    return r;
  endfunction

  function automatic logic [63:0] gen_data(input int w);
    logic [63:0] mask, r;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    r    = {$urandom, $urandom} & mask;
    case ($urandom_range(0, 5))
      2:       r = '0;
      3:       r = mask;
      4:       r = r >> $urandom_range(1, w);
      5:       r = ~(r >> $urandom_range(1, w)) & mask;
      default: ;
    endcase
    return r & mask;
  endfunction

  task automatic mon_dut(input int k, input int w, input logic vld, input logic irdy,
                         input logic [63:0] din, input logic [63:0] cnt, input logic [63:0] nrm,
                         input logic oa, input logic [63:0] ot);
    lzc_res_t e;
    if (vld) begin
      if (exp_q[k].size() == 0) begin
        chk_eq($sformatf("w%0d_unexpected_out", w), 64'd1, 64'd0);
      end else begin
        e = exp_q[k][0];
        chk_eq($sformatf("w%0d_count", w), cnt, 64'(e.count));
        chk_eq($sformatf("w%0d_norm", w), nrm, e.norm);
        chk_eq($sformatf("w%0d_all", w), 64'(oa), 64'(e.all));
        chk_eq($sformatf("w%0d_tag", w), ot, 64'(e.tag));
        if (out_ready) void'(exp_q[k].pop_front());
      end
    end
    if (in_valid && irdy) exp_q[k].push_back(ref_model(din, mode, w, tag));
  endtask

  // Scoreboard: sampled mid-cycle so values match what the next rising edge sees.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) exp_q[k].delete();
      chk_eq("rst_out_valid", 64'({ovld8, ovld32, ovld64}), 64'd0);
    end else begin
      mon_dut(0, 8,  ovld8,  irdy8,  64'(din8),  64'(cnt8),  64'(nrm8),  all8,  64'(otag8));
      mon_dut(1, 32, ovld32, irdy32, 64'(din32), 64'(cnt32), 64'(nrm32), all32, 64'(otag32));
      mon_dut(2, 64, ovld64, irdy64, din64,      64'(cnt64), nrm64,      all64, 64'(otag64));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  logic [31:0] v_data [7] = '{32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'hF0F0_0000,
                              32'hFFFF_FF80, 32'h0001_0000, 32'hFFFF_FFFF};
  logic [1:0]  v_mode [7] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 2'b11, 2'b01};
  logic [5:0]  v_cnt  [7] = '{6'd31, 6'd32, 6'd31, 6'd4, 6'd24, 6'd15, 6'd32};
  logic [31:0] v_norm [7] = '{32'h8000_0000, 32'h0, 32'h8000_0000, 32'h0F00_0000,
                              32'h8000_0000, 32'h8000_0000, 32'h0};
  logic        v_all  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  logic [TW-1:0] seen [$];
  logic [63:0]   r8, r32, r64;
  int            sent, emitted;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 2'b00; tag = '0;
    din8 = '0; din32 = '0; din64 = '0;
    #3;
    chk_eq("reset_out_valid", 64'(ovld32), 64'd0);
    chk_eq("reset_in_ready", 64'(irdy32), 64'd1);
    chk_eq("reset_count", 64'(cnt32), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed operands, one at a time, checking the two-cycle latency.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; mode = v_mode[i]; tag = TW'(i);
      din32 = v_data[i]; din8 = v_data[i][7:0]; din64 = {32'h0, v_data[i]};
      @(negedge clk);
      chk_eq("dir_in_ready", 64'(irdy32), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk_eq("dir_latency1", 64'(ovld32), 64'd0);
      @(posedge clk); #1;
      chk_eq("dir_valid", 64'(ovld32), 64'd1);
      chk_eq($sformatf("dir%0d_count", i), 64'(cnt32), 64'(v_cnt[i]));
      chk_eq($sformatf("dir%0d_norm", i), 64'(nrm32), 64'(v_norm[i]));
      chk_eq($sformatf("dir%0d_all", i), 64'(all32), 64'(v_all[i]));
      chk_eq($sformatf("dir%0d_tag", i), 64'(otag32), 64'(i));
      @(posedge clk); #1;
      chk_eq("dir_drained", 64'(ovld32), 64'd0);
    end

    // Stream of 8 tagged operands with a 3-cycle output stall.
    sent = 0; emitted = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (sent < 8);
      tag = TW'(sent); mode = 2'($urandom_range(0, 3));
      din32 = $urandom; din8 = din32[7:0]; din64 = {$urandom, din32};
      @(negedge clk);
      if (c >= 3 && c <= 5) begin
        chk_eq("stall_in_ready", 64'(irdy32), 64'd0);
        chk_eq("stall_out_valid", 64'(ovld32), 64'd1);
        chk_eq("stall_out_tag", 64'(otag32), 64'd1);
      end
      if (c >= 6 && emitted < 8) chk_eq("stream_continuous", 64'(ovld32), 64'd1);
      if (ovld32 && out_ready) begin
        seen.push_back(otag32);
        emitted++;
      end
      if (in_valid && irdy32) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk_eq("stream_sent", 64'(sent), 64'd8);
    chk_eq("stream_emitted", 64'(seen.size()), 64'd8);
    for (int i = 0; i < seen.size(); i++) chk_eq("stream_order", 64'(seen[i]), 64'(i));

    // Asynchronous reset with both stages holding data.
    out_ready = 1'b0; in_valid = 1'b1; mode = 2'b00;
    din32 = 32'h0000_00F0; din8 = 8'hF0; din64 = 64'hF0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); #2;
    chk_eq("prerst_out_valid", 64'(ovld32), 64'd1);
    chk_eq("prerst_in_ready", 64'(irdy32), 64'd0);
    rst = 1'b1;
    #1;
    chk_eq("async_rst_out_valid", 64'(ovld32), 64'd0);
    chk_eq("async_rst_in_ready", 64'(irdy32), 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("post_rst_idle", 64'(ovld32), 64'd0);
    end

    // First acceptance on the first edge after reset release.
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; mode = 2'b00; tag = TW'(5);
    din32 = 32'h0000_0100; din8 = 8'h01; din64 = 64'h100;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_eq("first_acc_ready", 64'(irdy32), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_eq("first_acc_lat1", 64'(ovld32), 64'd0);
    @(posedge clk); #1;
    chk_eq("first_acc_valid", 64'(ovld32), 64'd1);
    chk_eq("first_acc_count", 64'(cnt32), 64'd23);
    chk_eq("first_acc_tag", 64'(otag32), 64'd5);
    @(posedge clk); #1;

    // Random regression across all three widths.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      mode      = 2'($urandom_range(0, 3));
      tag       = TW'($urandom);
      r8 = gen_data(8); r32 = gen_data(32); r64 = gen_data(64);
      din8 = r8[7:0]; din32 = r32[31:0]; din64 = r64;
      if (c == 1500) rst = 1'b1;
      if (c == 1502) rst = 1'b0;
      @(posedge clk); #1;
    end

    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) chk_eq($sformatf("drain_q%0d", k), 64'(exp_q[k].size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lzc_norm_pipe.md
LZC_NORM_PIPE -- requirements
Module: lzc_norm_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand width; SHALL be a power of two, 4 to 64.
REQ-002 Parameter TAG_W, default 4, width of the sideband tag carried alongside each operand.
REQ-003 Localparam CNT_W SHALL equal clog2(WIDTH)+1 so that a count of WIDTH is representable.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 in_valid  in  1  operand offered.
REQ-007 in_ready  out  1  operand accepted when in_valid and in_ready are both high on a rising clk edge.
REQ-008 in_data  in  WIDTH  operand.
REQ-009 in_mode  in  2  operation: 00 CLZ, 01 CLO, 10 CLS, 11 reserved (SHALL be treated as CLZ).
REQ-010 in_tag  in  TAG_W  sideband, returned unchanged.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  result consumed when out_valid and out_ready are both high on a rising clk edge.
REQ-013 out_count  out  CNT_W  leading-bit count.
REQ-014 out_norm  out  WIDTH  operand shifted left by out_count, zero-filled.
REQ-015 out_all  out  1  set when the operand consists entirely of the counted bit.
REQ-016 out_tag  out  TAG_W  tag of this result.

Function
REQ-017 CLZ SHALL count leading zeros: WIDTH for an all-zero operand.
REQ-018 CLO SHALL count leading ones: WIDTH for an all-ones operand.
REQ-019 CLS SHALL count redundant sign bits, i.e. leading bits equal to bit WIDTH-1, minus one: WIDTH-1 for an operand of 0 or all-ones.
REQ-020 out_all SHALL be set only for: CLZ on all-zero; CLO on all-ones; CLS on 0 or all-ones.
REQ-021 out_norm SHALL be 0 whenever the shift equals WIDTH.
REQ-022 The block SHALL be a two-stage pipeline.
  - Stage 1 registers the count, operand, mode and tag.
  - Stage 2 registers the shifted result.
  - Latency from acceptance to out_valid is exactly 2 cycles when out_ready is held high.
REQ-023 Each stage SHALL accept new data when it is empty or its contents advance in the same cycle: ready_i = !valid_i | ready_(i+1).
  - in_ready SHALL be stage 1 ready.
  - Sustained throughput SHALL be one result per cycle.
REQ-024 in_ready SHALL NOT depend combinationally on in_valid.
REQ-025 While out_valid is high and out_ready is low, all out_* signals SHALL hold stable.
REQ-026 Results SHALL emerge in acceptance order; no operand shall be dropped or duplicated under any stall pattern.
REQ-027 Simultaneous accept and emit in one cycle SHALL be lossless when both stages are full.
REQ-028 Operands offered while in_ready is low SHALL be ignored.

Reset
REQ-029 On rst assertion the block SHALL, asynchronously, clear out_valid, both stage-valid flags and all datapath registers to 0.
REQ-030 During reset in_ready SHALL read 1, since stage 1 is empty.
REQ-031 Reset mid-operation SHALL discard in-flight operands; no stale result shall appear after release.
REQ-032 The first acceptance SHALL be possible on the first rising clk edge after rst deasserts.

Structure
REQ-033 Package lzc_pkg SHALL hold:
  - enum lzc_mode_e (CLZ, CLO, CLS);
  - the CNT_W computation function;
  - the result struct (count, norm, all, tag).
REQ-034 Counting SHALL reside in a combinational sub-module, lzc_core, parametrised by WIDTH.
  - lzc_core uses recursive halving (upper-half-zero select, log2(WIDTH) levels).
  - CLO and CLS are formed by conditional operand inversion before lzc_core.

Verification
REQ-035 WIDTH=32, CLZ, 0x0000_0001, out_ready high -> 2 cycles later: count 31, norm 0x8000_0000, all 0.
REQ-036 CLZ 0x0000_0000 -> count 32, norm 0, all 1; CLS 0xFFFF_FFFF -> count 31, all 1.
REQ-037 CLO 0xF0F0_0000 -> count 4, norm 0x0F00_0000; CLS 0xFFFF_FF80 -> count 24, norm 0x8000_0000, all 0.
REQ-038 Back-to-back stream of 8 tagged operands, out_ready low 3 cycles mid-stream:
  - in_ready falls after two operands are held;
  - outputs stay stable during the stall;
  - all 8 tags emerge in order, one per cycle after release.
REQ-039 rst asserted with both stages valid -> out_valid low in the same cycle, without a clock edge; after release, no output until a new acceptance plus 2 cycles.
REQ-040 Random regression, WIDTH 8/32/64, random valid/ready toggling, all modes, checked against a reference model including reserved mode 11 behaving as CLZ.
